prog_timer_mc: RTL and testbench
================================

Name: prog_timer_mc

Overview:
- Parametrised multi-channel programmable clock divider; next generation of the two-channel timer.
- NUM_CH independent down-counters with CNT_W-bit divisors, loaded over a narrow nibble bus with an explicit write strobe.
- Adds synchronous reset, a write-stall tolerant load FSM, error/done status, and a one-shot mode.
- Sits between the register-bus adapter and the clock-enable fabric; each out[i] drives a downstream enable.

Parameters:
NUM_CH, 4, number of channels (1..16)
CNT_W, 8, divisor/counter width; multiple of DATA_W
DATA_W, 4, data bus width; one beat per write
CNT_MIN, 2, smallest legal divisor, all channels
CNT_MAX, 200, largest legal divisor, all channels

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
wr_en  in  1  write strobe; a/d/ch_sel sampled only when high
a  in  2  address: 2'b10 control, 2'b00 data, others illegal
d  in  DATA_W  write data
ch_sel  in  clog2(NUM_CH) (min 1)  target channel, sampled with control write
g  in  NUM_CH  per-channel gate; counting and output enabled when high
out  out  NUM_CH  divided outputs
busy  out  1  load sequence in progress
done  out  1  one-cycle pulse: config committed
err  out  1  one-cycle pulse: sequence rejected

Behaviour:
- Reset (rst_n low at clk edge): out=0, busy=0, done=0, err=0; FSM->IDLE; every channel unprogrammed (cfg_vld=0, count=0, out forced 0). Mid-load reset discards the sequence with no err.
- Load FSM, NBEATS=CNT_W/DATA_W:
  IDLE: wr_en & a==10 -> capture ch_sel, mode=d[2:0]; ->LOAD, beat=0, busy=1. wr_en & a!=10 -> ignored.
  LOAD: wr_en & a==00 -> shift d into shadow, MSB beat first; beat++. No wr_en -> hold indefinitely. wr_en & a!=00 -> abort to IDLE, err pulse next cycle.
  Last beat -> validate at that edge; ->IDLE, busy=0 the following cycle.
- Validation, all must hold: CNT_MIN<=N<=CNT_MAX; mode<=5; ch_sel<NUM_CH; d[3]==0 on control beat; mode 2 N even; modes 3,4 N odd. Pass: channel N, mode, count=N, cfg_vld=1 written at the last-beat edge; done pulse next cycle. Fail: channel untouched; err pulse next cycle.
- Channels not being written run uninterrupted during a load. The target channel runs its old config until commit.
- Counter, per channel, when cfg_vld & g[i]: count==1 -> count=N, else count-1. g[i] low freezes count.
- Raw output: mode0 count==N; mode1 count!=N; mode2 count<=N/2; mode3 count<=(N-1)/2; mode4 count<=(N+1)/2; mode5 one-shot, high while count>1, count holds at 1 (no reload) until next commit.
- out[i] = raw & g[i] & cfg_vld[i], combinational from registered count.
- done and err never assert in the same cycle.

Optional Feature:
- Macro GATE_RETRIGGER_EN.
- Defined: rising edge of g[i] (registered g[i] previous 0, current 1) reloads count=N on that clk edge, restarting the phase; re-arms mode 5.
- Undefined: gate only pauses and resumes; count is preserved across gate low.

Test Plan:
- Reset with all g=1 -> out=0, busy=0, no done/err. Load ch2 mode0 N=0x05 (ctrl 0x0, beats 0x0,0x5) -> done 1 cycle after last beat; out[2] high 1 of every 5 clks.
- Load ch0 mode2 N=7 -> err pulse, ch0 unchanged. Load ch1 N=201 -> err pulse. Load ch3 N=1 -> err pulse.
- Control write, 3 idle cycles, then 2 beats N=0x0A mode2 on ch1 -> busy held through the stall; commit; out[1] 5 low then 5 high. ch0 counting undisturbed throughout.
- Mid-load control write (a=10) -> err pulse, FSM back to IDLE; an immediate new full sequence then commits normally.
- ch0 mode5 N=4, g[0]=1 -> out[0] high 3 clks then low and stays low; a new commit re-arms it.
- ch0 mode3 N=9, drop g[0] for 4 clks mid-period -> out[0]=0 while gated; phase resumes (or restarts under GATE_RETRIGGER_EN). Assert rst_n low mid-beat -> no err, busy=0.

Source files
------------

// File: rtl/prog_timer_mc_if.sv
// Register-write side of prog_timer_mc: nibble write bus plus load status.
// Handshake: wr_en qualifies a/d/ch_sel for exactly the cycle it is high and there is no
// back-pressure (every strobed beat is consumed); busy/done/err are status outputs, not a ready.
interface prog_timer_mc_if #(
  parameter int DATA_W = 4,
  parameter int CH_W   = 2
);
  logic              wr_en;
  logic [1:0]        a;
  logic [DATA_W-1:0] d;
  logic [CH_W-1:0]   ch_sel;
  logic              busy;
  logic              done;
  logic              err;

  modport master (output wr_en, a, d, ch_sel, input busy, done, err);
  modport slave  (input wr_en, a, d, ch_sel, output busy, done, err);
endinterface

// File: rtl/prog_timer_mc.sv
// Multi-channel programmable clock divider with a nibble-bus load FSM.
// Optional macro GATE_RETRIGGER_EN: a rising gate edge reloads the channel counter.
module prog_timer_mc #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int DATA_W  = 4,
  parameter int CNT_MIN = 2,
  parameter int CNT_MAX = 200,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  prog_timer_mc_if.slave     bus,
  input  logic [NUM_CH-1:0]  g,
  output logic [NUM_CH-1:0]  out,
  output logic               dbg_state
);
  localparam int NBEATS = CNT_W / DATA_W;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
  localparam logic [CNT_W-1:0]  N_MIN     = CNT_W'(CNT_MIN);
  localparam logic [CNT_W-1:0]  N_MAX     = CNT_W'(CNT_MAX);

  typedef enum logic [0:0] {IDLE, LOAD} state_t;
  state_t state, state_n;

  logic [CH_W-1:0]   ch_q;
  logic [2:0]        mode_q;
  logic              ctrl_bad_q;
  logic [CNT_W-1:0]  shadow_q;
  logic [BEAT_W-1:0] beat_q;
  logic              done_q, err_q;
  logic              cap_ctrl, shift_beat, commit, reject;
  logic [CNT_W-1:0]  n_new;
  logic              cfg_ok;

  // Divisor as it stands once the current beat is shifted in (MSB beat first).
  assign n_new  = (shadow_q << DATA_W) | CNT_W'(bus.d);
  assign cfg_ok = (n_new >= N_MIN) && (n_new <= N_MAX) && (mode_q <= 3'd5)
               && (32'(ch_q) < NUM_CH) && !ctrl_bad_q
               && !(mode_q == 3'd2 && n_new[0])
               && !((mode_q == 3'd3 || mode_q == 3'd4) && !n_new[0]);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    cap_ctrl   = 1'b0;
    shift_beat = 1'b0;
    commit     = 1'b0;
    reject     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.wr_en && bus.a == 2'b10) begin
          cap_ctrl = 1'b1;
          state_n  = LOAD;
        end
      end
      LOAD: begin
        if (bus.wr_en) begin
          if (bus.a == 2'b00) begin
            shift_beat = 1'b1;
            if (beat_q == LAST_BEAT) begin
              state_n = IDLE;
              commit  = cfg_ok;
              reject  = !cfg_ok;
            end
          end else begin
            state_n = IDLE;
            reject  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_q       <= '0;
      mode_q     <= '0;
      ctrl_bad_q <= 1'b0;
      shadow_q   <= '0;
      beat_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= commit;
      err_q  <= reject;
      if (cap_ctrl) begin
        ch_q       <= bus.ch_sel;
        mode_q     <= bus.d[2:0];
        ctrl_bad_q <= bus.d[3];
        shadow_q   <= '0;
        beat_q     <= '0;
      end else if (shift_beat) begin
        shadow_q <= n_new;
        beat_q   <= beat_q + BEAT_W'(1);
      end
    end
  end

  assign bus.busy  = (state == LOAD);
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign dbg_state = state;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] n_r, cnt_r;
    logic [2:0]       mode_r;
    logic             vld_r, raw, wr_hit, g_rise;
    logic [CNT_W:0]   n_ext, c_ext;

    assign wr_hit = commit && (32'(ch_q) == i);
    assign n_ext  = {1'b0, n_r};
    assign c_ext  = {1'b0, cnt_r};

`ifdef GATE_RETRIGGER_EN
    logic g_q;
    always_ff @(posedge clk) begin
      if (!rst_n) g_q <= 1'b0;
      else        g_q <= g[i];
    end
    assign g_rise = g[i] & ~g_q;
`else
    assign g_rise = 1'b0;
`endif

    // Commit wins over counting; mode 5 parks at 1 until the next commit.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        n_r    <= '0;
        cnt_r  <= '0;
        mode_r <= '0;
        vld_r  <= 1'b0;
      end else if (wr_hit) begin
        n_r    <= n_new;
        cnt_r  <= n_new;
        mode_r <= mode_q;
        vld_r  <= 1'b1;
      end else if (vld_r && g_rise) begin
        cnt_r <= n_r;
      end else if (vld_r && g[i]) begin
        if (cnt_r == CNT_W'(1)) begin
          if (mode_r != 3'd5) cnt_r <= n_r;
        end else begin
          cnt_r <= cnt_r - CNT_W'(1);
        end
      end
    end

    always_comb begin
      raw = 1'b0;
      case (mode_r)
        3'd0:    raw = (cnt_r == n_r);
        3'd1:    raw = (cnt_r != n_r);
        3'd2:    raw = (c_ext <= (n_ext >> 1));
        3'd3:    raw = (c_ext <= ((n_ext - (CNT_W+1)'(1)) >> 1));
        3'd4:    raw = (c_ext <= ((n_ext + (CNT_W+1)'(1)) >> 1));
        3'd5:    raw = (cnt_r > CNT_W'(1));
        default: raw = 1'b0;
      endcase
    end

    assign out[i] = raw & g[i] & vld_r;
  end
endmodule

// File: tb/tb_prog_timer_mc.sv
// Self-checking bench for prog_timer_mc: tick-count reference model plus directed literal checks.
module tb_prog_timer_mc;
  localparam int NUM_CH = 4, CNT_W = 8, DATA_W = 4, CH_W = 2, CNT_MIN = 2, CNT_MAX = 200;
  localparam int NBEATS = CNT_W / DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] g = '1;
  logic [NUM_CH-1:0] out;
  logic              dbg_state;

  prog_timer_mc_if #(.DATA_W(DATA_W), .CH_W(CH_W)) bus ();

  prog_timer_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DATA_W(DATA_W),
                  .CNT_MIN(CNT_MIN), .CNT_MAX(CNT_MAX), .CH_W(CH_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .g(g), .out(out), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_vec = 0, n_fail = 0;
  bit chk_en = 1'b0;

  // ---------------- reference model ----------------
  // Channel state is "gated cycles elapsed since commit"; count/outputs are derived arithmetically.
  bit m_load, m_bad, m_done, m_err;
  int m_ch, m_mode, m_val, m_k;
  bit m_vld [NUM_CH];
  int m_n   [NUM_CH];
  int m_md  [NUM_CH];
  int m_t   [NUM_CH];
  bit m_gp  [NUM_CH];

  function automatic bit cfg_legal();
    if (m_val < CNT_MIN || m_val > CNT_MAX) return 1'b0;
    if (m_mode > 5 || m_ch >= NUM_CH || m_bad) return 1'b0;
    if (m_mode == 2 && (m_val % 2) == 1) return 1'b0;
    if ((m_mode == 3 || m_mode == 4) && (m_val % 2) == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_out(int i);
    int c, n;
    n = m_n[i];
    if (!m_vld[i] || !g[i]) return 1'b0;
    if (m_md[i] == 5) c = (m_t[i] >= n - 1) ? 1 : n - m_t[i];
    else              c = n - (m_t[i] % n);
    case (m_md[i])
      0: return c == n;
      1: return c != n;
      2: return c <= n / 2;
      3: return c <= (n - 1) / 2;
      4: return c <= (n + 1) / 2;
      5: return c > 1;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    bit nd, ne;
    nd = 1'b0;
    ne = 1'b0;
    if (!rst_n) begin
      m_load = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_vld[i] = 1'b0; m_n[i] = 0; m_md[i] = 0; m_t[i] = 0; m_gp[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (m_vld[i]) begin
`ifdef GATE_RETRIGGER_EN
          if (g[i] && !m_gp[i]) m_t[i] = 0;
          else if (g[i])        m_t[i] = m_t[i] + 1;
`else
          if (g[i]) m_t[i] = m_t[i] + 1;
`endif
        end
        m_gp[i] = g[i];
      end
      if (bus.wr_en) begin
        if (!m_load) begin
          if (bus.a == 2'b10) begin
            m_load = 1'b1; m_ch = int'(bus.ch_sel); m_mode = int'(bus.d[2:0]);
            m_bad = bus.d[3]; m_val = 0; m_k = 0;
          end
        end else if (bus.a == 2'b00) begin
          m_val = m_val * (1 << DATA_W) + int'(bus.d);
          m_k   = m_k + 1;
          if (m_k == NBEATS) begin
            m_load = 1'b0;
            if (cfg_legal()) begin
              m_vld[m_ch] = 1'b1; m_n[m_ch] = m_val; m_md[m_ch] = m_mode; m_t[m_ch] = 0;
              nd = 1'b1;
            end else begin
              ne = 1'b1;
            end
          end
        end else begin
          m_load = 1'b0;
          ne = 1'b1;
        end
      end
    end
    m_done = nd;
    m_err  = ne;
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [NUM_CH-1:0] exp_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      logic [NUM_CH-1:0] ev;
      for (int i = 0; i < NUM_CH; i++) ev[i] = exp_out(i);
      exp_q.push_back(ev);
      chk("busy", 32'(bus.busy), 32'(m_load));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("err",  32'(bus.err),  32'(m_err));
      chk("out",  32'(out),      32'(exp_q.pop_front()));
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [1:0] aa, input logic [DATA_W-1:0] dd, input logic [CH_W-1:0] cc);
    bus.wr_en = 1'b1; bus.a = aa; bus.d = dd; bus.ch_sel = cc;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic load(input int ch, input int mode, input int n, input bit bad);
    logic [DATA_W-1:0] cw;
    cw = DATA_W'({bad, 3'(mode)});
    wr(2'b10, cw, CH_W'(ch));
    for (int b = 0; b < NBEATS; b++) wr(2'b00, DATA_W'(n >> (DATA_W * (NBEATS - 1 - b))), '0);
  endtask

  task automatic sample_pat(input int ch, input int n, output logic [31:0] pat, output logic dn);
    pat = '0;
    dn  = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) dn = bus.done;
      pat = {pat[30:0], out[ch]};
    end
  endtask

  task automatic expect_err(input string nm);
    @(negedge clk);
    chk({nm, "_err"},  32'(bus.err),  32'd1);
    chk({nm, "_done"}, 32'(bus.done), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] pat;
    logic        dn;
    bus.wr_en = 1'b0; bus.a = '0; bus.d = '0; bus.ch_sel = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    idle(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out",  32'(out),      32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err",  32'(bus.err),  32'd0);

    // ch2 mode0 N=5: one high cycle in five, starting on the done cycle
    load(2, 0, 5, 1'b0);
    sample_pat(2, 10, pat, dn);
    chk("m0_done", 32'(dn), 32'd1);
    chk("m0_pat",  pat, 32'b1000010000);

    load(0, 2, 7, 1'b0);   expect_err("m2_odd");
    load(1, 0, 201, 1'b0); expect_err("n_big");
    load(3, 0, 1, 1'b0);   expect_err("n_small");
    load(2, 6, 5, 1'b0);   expect_err("bad_mode");
    load(2, 0, 5, 1'b1);   expect_err("ctrl_d3");

    // ch0 runs mode1 N=3 while ch1 loads through a write stall
    load(0, 1, 3, 1'b0);
    idle(2);
    wr(2'b10, DATA_W'(2), CH_W'(1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_busy", 32'(bus.busy), 32'd1);
      @(posedge clk); #1;
    end
    wr(2'b00, DATA_W'(0), '0);
    wr(2'b00, DATA_W'(10), '0);
    sample_pat(1, 10, pat, dn);
    chk("m2_done", 32'(dn), 32'd1);
    chk("m2_pat",  pat, 32'b0000011111);

    // control write in the middle of a load aborts, then a fresh sequence commits
    wr(2'b10, DATA_W'(0), CH_W'(3));
    wr(2'b00, DATA_W'(0), '0);
    wr(2'b10, DATA_W'(0), CH_W'(3));
    @(negedge clk);
    chk("abort_err",  32'(bus.err),  32'd1);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    load(3, 1, 6, 1'b0);
    @(negedge clk);
    chk("reload_done", 32'(bus.done), 32'd1);

    // ch0 one-shot N=4, then re-armed by a second commit
    load(0, 5, 4, 1'b0);
    sample_pat(0, 8, pat, dn);
    chk("m5_pat", pat, 32'b11100000);
    load(0, 5, 4, 1'b0);
    sample_pat(0, 4, pat, dn);
    chk("m5_rearm", pat, 32'b1110);

    // ch0 mode3 N=9 gated for four cycles mid-period
    load(0, 3, 9, 1'b0);
    idle(3);
    g[0] = 1'b0;
    sample_pat(0, 4, pat, dn);
    chk("gated_low", pat, 32'd0);
    @(posedge clk); #1;
    g[0] = 1'b1;
    idle(20);

    // reset in the middle of a load: no err, not busy
    wr(2'b10, DATA_W'(0), CH_W'(1));
    wr(2'b00, DATA_W'(0), '0);
    do_reset();
    @(negedge clk);
    chk("midrst_err",  32'(bus.err),  32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_out",  32'(out),      32'd0);

    // randomized sequences, stalls, aborts, gate toggles and resets
    for (int it = 0; it < 400; it++) begin
      int r, mode, nval;
      bit bad;
      for (int i = 0; i < NUM_CH; i++)
        if ($urandom_range(0, 5) == 0) g[i] = ~g[i];
      r = $urandom_range(0, 19);
      if (r == 0) begin
        do_reset();
      end else if (r < 12) begin
        mode = $urandom_range(0, 6);
        bad  = ($urandom_range(0, 9) == 0);
        nval = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(2, 30);
        wr(2'b10, DATA_W'({bad, 3'(mode)}), CH_W'($urandom_range(0, NUM_CH - 1)));
        for (int b = 0; b < NBEATS; b++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          if ($urandom_range(0, 24) == 0)
            wr(2'($urandom_range(1, 3)), DATA_W'($urandom), CH_W'($urandom));
          wr(2'b00, DATA_W'(nval >> (DATA_W * (NBEATS - 1 - b))), CH_W'($urandom));
        end
      end else begin
        if ($urandom_range(0, 9) == 0) wr(2'($urandom_range(0, 3)), DATA_W'($urandom), CH_W'($urandom));
        idle($urandom_range(1, 15));
      end
    end
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
